// File: rtl/div_pkg.sv
// Shared encodings and constants for the iterative divide/remainder unit.
package div_pkg;
  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFFFFFF;
  localparam int          CNT_W      = 5;

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_FIX, ST_DONE} div_state_e;

  // Magnitude of a two's-complement value when the op is signed, else pass-through.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? -v : v;
  endfunction
endpackage

// File: rtl/div_step.sv
// One restoring-division step: 33-bit trial subtract of the divisor from the shifted remainder.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   shifted,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic             qbit
);
  logic [WIDTH:0] trial;

  assign trial    = shifted - {1'b0, divisor};
  assign qbit     = ~trial[WIDTH];
  assign rem_next = qbit ? trial : shifted;
endmodule

// File: rtl/iter_div_unit.sv
// RV32 multi-cycle divide/remainder: one quotient bit per clock, sign fix-up in a final FIX cycle.
module iter_div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Y,
  output logic             Z,
  output logic             DZ
);
  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       opr;
  logic [WIDTH-1:0] dividend, divisor, quo, base, fix_y;
  logic [WIDTH:0]   rem, rem_next;
  logic             qbit, qneg, rneg, dz_q, neg;
  logic             accept, sgn_op;

  assign accept = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign sgn_op = ~op[0];

  div_step #(.WIDTH(WIDTH)) u_step (
    .shifted  ({rem[WIDTH-1:0], dividend[cnt]}),
    .divisor  (divisor),
    .rem_next (rem_next),
    .qbit     (qbit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept)                 state_d = (B == '0) ? ST_FIX : ST_CALC;
        else if (state_q == ST_DONE) state_d = ST_IDLE;
      end
      ST_CALC: if (cnt == '0) state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_CALC) || (state_q == ST_FIX);
    done = (state_q == ST_DONE);
  end

  // Divide-by-zero remainder reuses |A| with the A sign, which reconstructs A exactly.
  always_comb begin
    base  = opr[1] ? (dz_q ? dividend : rem[WIDTH-1:0]) : quo;
    neg   = ~opr[0] & (opr[1] ? rneg : qneg);
    fix_y = neg ? -base : base;
    if (dz_q && !opr[1]) fix_y = DIV_ZERO_Q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      opr      <= '0;
      dividend <= '0;
      divisor  <= '0;
      quo      <= '0;
      rem      <= '0;
      qneg     <= 1'b0;
      rneg     <= 1'b0;
      dz_q     <= 1'b0;
      Y        <= '0;
      Z        <= 1'b0;
      DZ       <= 1'b0;
    end else if (accept) begin
      opr      <= op;
      dividend <= abs32(A, sgn_op);
      divisor  <= abs32(B, sgn_op);
      qneg     <= sgn_op & (A[WIDTH-1] ^ B[WIDTH-1]);
      rneg     <= sgn_op & A[WIDTH-1];
      dz_q     <= (B == '0);
      rem      <= '0;
      quo      <= '0;
      cnt      <= CNT_W'(WIDTH - 1);
    end else if (state_q == ST_CALC) begin
      rem <= rem_next;
      quo <= {quo[WIDTH-2:0], qbit};
      cnt <= cnt - 1'b1;
    end else if (state_q == ST_FIX) begin
      Y  <= fix_y;
      Z  <= (fix_y == '0);
      DZ <= dz_q;
    end
  end
endmodule

// File: tb/tb_iter_div_unit.sv
// Directed bench for iter_div_unit: results, flags, latency, ignored/back-to-back start, mid-op reset.
module tb_iter_div_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] A = '0, B = '0;
  logic        busy, done, Z, DZ;
  logic [31:0] Y;
  int          checks = 0;
  int          failures = 0;
  int          overlap_err = 0;

  iter_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .done(done), .Y(Y), .Z(Z), .DZ(DZ)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (busy && done) overlap_err++;

  // Accepts at the next posedge, then counts cycles until done (-1 on timeout).
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
    @(negedge clk);
    op = o; A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done) lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++;
    if ({busy, done, Y, Z, DZ} !== 35'd0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%b done=%b Y=%h Z=%b DZ=%b want all 0", busy, done, Y, Z, DZ);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_unsigned();
    int lat;
    run_op(2'b01, 32'd100, 32'd7, lat);
    checks++; if (lat !== 33) begin failures++; $display("FAIL divu_latency got %0d want 33", lat); end
    checks++; if (Y !== 32'd14) begin failures++; $display("FAIL divu_y got %h want 0000000e", Y); end
    checks++; if (Z !== 1'b0 || DZ !== 1'b0) begin failures++; $display("FAIL divu_flags got Z=%b DZ=%b want 0 0", Z, DZ); end
    run_op(2'b11, 32'd100, 32'd7, lat);
    checks++; if (Y !== 32'd2) begin failures++; $display("FAIL remu_y got %h want 00000002", Y); end
  endtask

  task automatic test_signed();
    int lat;
    run_op(2'b00, 32'hFFFFFFF9, 32'd2, lat);
    checks++; if (Y !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_neg_y got %h want fffffffd", Y); end
    run_op(2'b10, 32'hFFFFFFF9, 32'd2, lat);
    checks++; if (Y !== 32'hFFFFFFFF) begin failures++; $display("FAIL rem_neg_y got %h want ffffffff", Y); end
    run_op(2'b00, 32'd7, 32'hFFFFFFFE, lat);
    checks++; if (Y !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_negb_y got %h want fffffffd", Y); end
  endtask

  task automatic test_overflow();
    int lat;
    run_op(2'b00, 32'h80000000, 32'hFFFFFFFF, lat);
    checks++; if (Y !== 32'h80000000) begin failures++; $display("FAIL ovf_div_y got %h want 80000000", Y); end
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, lat);
    checks++; if (Y !== 32'h0 || Z !== 1'b1) begin failures++; $display("FAIL ovf_rem got Y=%h Z=%b want 00000000 1", Y, Z); end
  endtask

  task automatic test_div_zero();
    int lat;
    run_op(2'b01, 32'd5, 32'd0, lat);
    checks++; if (lat !== 1) begin failures++; $display("FAIL dz_latency got %0d want 1", lat); end
    checks++; if (Y !== 32'hFFFFFFFF || DZ !== 1'b1) begin failures++; $display("FAIL dz_divu got Y=%h DZ=%b want ffffffff 1", Y, DZ); end
    run_op(2'b10, 32'hFFFFFFFB, 32'd0, lat);
    checks++; if (Y !== 32'hFFFFFFFB || DZ !== 1'b1) begin failures++; $display("FAIL dz_rem got Y=%h DZ=%b want fffffffb 1", Y, DZ); end
    run_op(2'b00, 32'hFFFFFFFB, 32'd0, lat);
    checks++; if (Y !== 32'hFFFFFFFF) begin failures++; $display("FAIL dz_div got %h want ffffffff", Y); end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] prev;
    prev = Y;
    @(negedge clk);
    op = 2'b01; A = 32'd1000; B = 32'd10; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    op = 2'b11; A = 32'd7; B = 32'd1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    checks++; if (Y !== prev) begin failures++; $display("FAIL y_held_in_calc got %h want %h", Y, prev); end
    lat = 11;
    while (!done && lat < 60) begin @(posedge clk); #1; lat++; end
    checks++; if (lat !== 33) begin failures++; $display("FAIL ignored_start_latency got %0d want 33", lat); end
    checks++; if (Y !== 32'd100) begin failures++; $display("FAIL ignored_start_y got %h want 00000064", Y); end
    op = 2'b01; A = 32'd9; B = 32'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL b2b_accept got busy=%b done=%b want 1 0", busy, done); end
    lat = 0;
    while (!done && lat < 60) begin @(posedge clk); #1; lat++; end
    checks++; if (lat !== 33 || Y !== 32'd3) begin failures++; $display("FAIL b2b_result got lat=%0d Y=%h want 33 00000003", lat, Y); end
  endtask

  task automatic test_reset_mid();
    int lat;
    @(negedge clk);
    op = 2'b01; A = 32'd500; B = 32'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (15) begin @(posedge clk); #1; end
    rst = 1'b1; #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || Y !== 32'h0) begin failures++; $display("FAIL mid_reset got busy=%b done=%b Y=%h want 0 0 00000000", busy, done, Y); end
    @(negedge clk); rst = 1'b0;
    run_op(2'b01, 32'd9, 32'd3, lat);
    checks++; if (lat !== 33 || Y !== 32'd3) begin failures++; $display("FAIL post_reset got lat=%0d Y=%h want 33 00000003", lat, Y); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_overflow();
    test_div_zero();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (overlap_err !== 0) begin failures++; $display("FAIL busy_done_overlap got %0d cycles want 0", overlap_err); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
